// File: rtl/mxn_wbits_reg.sv
// ---------------------------------------------------------------------------
// mxn_wbits_reg
//   N-channel, W-bit selector with a one-entry registered output and a
//   valid/ready handshake on both sides. In mode 0 the channel is chosen by
//   sel; in mode 1 an internal scan pointer walks the channels 0..NCH-1 and
//   advances once per accepted capture.
//
// Configuration macro:
//   MXN_PARITY_EN - when defined, adds output y_par (even parity of the
//                   captured word, registered with y). Out-of-range selects
//                   give y_par = 0.
//
// Parameters:
//   WIDTH  bits per channel (>= 1)
//   NCH    number of input channels (>= 2, need not be a power of 2)
//   SELW   derived channel-index width, $clog2(NCH)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   d_in       packed channels, channel k = d_in[k*WIDTH +: WIDTH]
//   in_valid   capture request
//   in_ready   capture can be accepted this cycle (~out_valid | out_ready)
//   sel        channel select used in mode 0
//   mode       0 = fixed select, 1 = round-robin scan
//   out_valid  y / y_ch hold a captured word
//   out_ready  consumer takes y this cycle
//   y          registered selected word
//   y_ch       channel index that produced y
//   y_par      even parity of y (MXN_PARITY_EN only)
// ---------------------------------------------------------------------------
module mxn_wbits_reg #(
  parameter  int WIDTH = 4,
  parameter  int NCH   = 8,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] d_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     y,
  output logic [SELW-1:0]      y_ch
`ifdef MXN_PARITY_EN
  ,
  output logic                 y_par
`endif
);

  // Unpacked view of the input channels.
  logic [WIDTH-1:0] chans [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_unpack
      assign chans[gi] = d_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic              out_valid_reg, out_valid_next;
  logic [WIDTH-1:0]  y_reg, y_next;
  logic [SELW-1:0]   y_ch_reg, y_ch_next;
  logic [SELW-1:0]   ptr_reg, ptr_next;
`ifdef MXN_PARITY_EN
  logic              y_par_reg, y_par_next;
`endif

  logic [SELW-1:0]   ch;
  logic [WIDTH-1:0]  sel_word;
  logic              capture;

  assign in_ready = ~out_valid_reg | out_ready;
  assign capture  = in_valid & in_ready;
  assign ch       = mode ? ptr_reg : sel;

  // Decode by comparison rather than array indexing so that an index
  // >= NCH (possible when NCH is not a power of 2) cleanly yields zero.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch == SELW'(k)) begin
        sel_word = chans[k];
      end
    end
  end

  always_comb begin
    out_valid_next = out_valid_reg;
    y_next         = y_reg;
    y_ch_next      = y_ch_reg;
    ptr_next       = ptr_reg;
`ifdef MXN_PARITY_EN
    y_par_next     = y_par_reg;
`endif
    if (capture) begin
      // A capture wins over a drain in the same cycle, so the register
      // stays full and throughput is one word per cycle.
      out_valid_next = 1'b1;
      y_next         = sel_word;
      y_ch_next      = ch;
`ifdef MXN_PARITY_EN
      y_par_next     = ^sel_word;
`endif
      if (mode) begin
        ptr_next = (ptr_reg == SELW'(NCH - 1)) ? '0 : ptr_reg + SELW'(1);
      end
    end else if (out_valid_reg && out_ready) begin
      // Drain only; data keeps its last value.
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      y_ch_reg      <= '0;
      ptr_reg       <= '0;
`ifdef MXN_PARITY_EN
      y_par_reg     <= 1'b0;
`endif
    end else begin
      out_valid_reg <= out_valid_next;
      y_reg         <= y_next;
      y_ch_reg      <= y_ch_next;
      ptr_reg       <= ptr_next;
`ifdef MXN_PARITY_EN
      y_par_reg     <= y_par_next;
`endif
    end
  end

  assign out_valid = out_valid_reg;
  assign y         = y_reg;
  assign y_ch      = y_ch_reg;
`ifdef MXN_PARITY_EN
  assign y_par     = y_par_reg;
`endif

endmodule

// File: tb/tb_mxn_wbits_reg.sv
// ---------------------------------------------------------------------------
// tb_mxn_wbits_reg
//   Directed bench for mxn_wbits_reg. Two instances: an 8-channel one for
//   select, back-pressure, scan and reset behaviour, and a 6-channel one for
//   out-of-range selects and scan wrap at a non power-of-2 boundary.
//   Channel k carries the value k+3 unless a step overrides it.
// ---------------------------------------------------------------------------
module tb_mxn_wbits_reg;

  logic        clk = 1'b0;
  logic        reset;

  // 8-channel instance
  logic [31:0] d_in8;
  logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8;
  logic [2:0]  sel8, y_ch8;
  logic [3:0]  y8;
  // 6-channel instance
  logic [23:0] d_in6;
  logic        in_valid6, in_ready6, mode6, out_valid6, out_ready6;
  logic [2:0]  sel6, y_ch6;
  logic [3:0]  y6;
`ifdef MXN_PARITY_EN
  logic        y_par8, y_par6;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mxn_wbits_reg #(.WIDTH(4), .NCH(8)) dut8 (
    .clk(clk), .reset(reset), .d_in(d_in8), .in_valid(in_valid8),
    .in_ready(in_ready8), .sel(sel8), .mode(mode8), .out_valid(out_valid8),
    .out_ready(out_ready8), .y(y8), .y_ch(y_ch8)
`ifdef MXN_PARITY_EN
    , .y_par(y_par8)
`endif
  );

  mxn_wbits_reg #(.WIDTH(4), .NCH(6)) dut6 (
    .clk(clk), .reset(reset), .d_in(d_in6), .in_valid(in_valid6),
    .in_ready(in_ready6), .sel(sel6), .mode(mode6), .out_valid(out_valid6),
    .out_ready(out_ready6), .y(y6), .y_ch(y_ch6)
`ifdef MXN_PARITY_EN
    , .y_par(y_par6)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    in_valid8  = 1'b0; out_ready8 = 1'b0; mode8 = 1'b0; sel8 = 3'd0;
    in_valid6  = 1'b0; out_ready6 = 1'b0; mode6 = 1'b0; sel6 = 3'd0;
    for (int k = 0; k < 8; k++) d_in8[k*4 +: 4] = 4'(k + 3);
    for (int k = 0; k < 6; k++) d_in6[k*4 +: 4] = 4'(k + 3);

    // Reset state
    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_y", 32'(y8), 32'd0);
    check("rst_y_ch", 32'(y_ch8), 32'd0);
    check("rst_in_ready", 32'(in_ready8), 32'd1);
    reset = 1'b0;

    // Fixed select: channel 5 carries 8
    sel8 = 3'd5; in_valid8 = 1'b1; out_ready8 = 1'b1;
    tick();
    check("fix_y", 32'(y8), 32'h8);
    check("fix_y_ch", 32'(y_ch8), 32'd5);
    check("fix_out_valid", 32'(out_valid8), 32'd1);

    // Back-pressure for 3 cycles while sel moves to 2
    out_ready8 = 1'b0; sel8 = 3'd2;
    #1;
    check("bp_in_ready_now", 32'(in_ready8), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_y", 32'(y8), 32'h8);
      check("bp_y_ch", 32'(y_ch8), 32'd5);
      check("bp_in_ready", 32'(in_ready8), 32'd0);
      check("bp_out_valid", 32'(out_valid8), 32'd1);
    end
    out_ready8 = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready8), 32'd1);
    tick();
    check("bp_cap_y", 32'(y8), 32'h5);
    check("bp_cap_y_ch", 32'(y_ch8), 32'd2);
    check("bp_cap_out_valid", 32'(out_valid8), 32'd1);

    // Drain without capture: valid drops, data held
    in_valid8 = 1'b0;
    tick();
    check("drain_out_valid", 32'(out_valid8), 32'd0);
    check("drain_y", 32'(y8), 32'h5);
    check("drain_y_ch", 32'(y_ch8), 32'd2);

    // Scan mode: 10 captures, wraps 7 -> 0
    mode8 = 1'b1; in_valid8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("scan_y_ch_%0d", i), 32'(y_ch8), 32'(i % 8));
      check($sformatf("scan_y_%0d", i), 32'(y8), 32'((i % 8) + 3));
    end

    // Two fixed-select captures leave the pointer at 2
    mode8 = 1'b0; sel8 = 3'd6;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mode0_y_ch", 32'(y_ch8), 32'd6);
      check("mode0_y", 32'(y8), 32'd9);
    end
    mode8 = 1'b1;
    tick();
    check("resume_y_ch", 32'(y_ch8), 32'd2);
    check("resume_y", 32'(y8), 32'd5);

    // Stall in scan mode: pointer must not advance without a capture
    out_ready8 = 1'b0;
    repeat (2) begin
      tick();
      check("scan_stall_y_ch", 32'(y_ch8), 32'd2);
    end
    out_ready8 = 1'b1;
    tick();
    check("scan_after_stall_y_ch", 32'(y_ch8), 32'd3);
    check("scan_after_stall_y", 32'(y8), 32'd6);

    // Asynchronous reset mid-cycle with out_valid=1
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid8), 32'd0);
    check("async_rst_y", 32'(y8), 32'd0);
    check("async_rst_y_ch", 32'(y_ch8), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    check("post_rst_ptr_y_ch", 32'(y_ch8), 32'd0);
    check("post_rst_y", 32'(y8), 32'd3);

    // Parity words on channels 3 and 4
    mode8 = 1'b0;
    d_in8[3*4 +: 4] = 4'b1011; sel8 = 3'd3;
    tick();
    check("par1_y", 32'(y8), 32'hB);
`ifdef MXN_PARITY_EN
    check("par1_y_par", 32'(y_par8), 32'd1);
`endif
    d_in8[4*4 +: 4] = 4'b0110; sel8 = 3'd4;
    tick();
    check("par0_y", 32'(y8), 32'h6);
`ifdef MXN_PARITY_EN
    check("par0_y_par", 32'(y_par8), 32'd0);
`endif
    in_valid8 = 1'b0;

    // Out-of-range select on the 6-channel instance
    sel6 = 3'd7; in_valid6 = 1'b1; out_ready6 = 1'b1;
    tick();
    check("oor_y", 32'(y6), 32'd0);
    check("oor_y_ch", 32'(y_ch6), 32'd7);
    check("oor_out_valid", 32'(out_valid6), 32'd1);
`ifdef MXN_PARITY_EN
    check("oor_y_par", 32'(y_par6), 32'd0);
`endif
    sel6 = 3'd5;
    tick();
    check("nch6_last_y", 32'(y6), 32'h8);

    // Scan wrap at 5 -> 0 on the 6-channel instance
    mode6 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("scan6_y_ch_%0d", i), 32'(y_ch6), 32'(i % 6));
      check($sformatf("scan6_y_%0d", i), 32'(y6), 32'((i % 6) + 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
